enigma_keystroke_sequencer: RTL and testbench

- Sequences one Enigma encryption per keystroke: accepts a one-hot letter from the PS/2 keyboard decoder and advances a three-rotor odometer with true double-stepping.
- Drives the latched letter and rotor positions into the rotor/reflector/rotor datapath, waits a fixed settle time, then captures the binary cipher letter.
- Hands the captured letter to the VGA display with a valid/ready handshake.
- Replaces the manual KEY-button rotate strobe with automatic per-keystroke stepping.

---
 rtl/enigma_keystroke_sequencer.sv | 176 +++++++++++++++++
 tb/tb_enigma_keystroke_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/enigma_keystroke_sequencer.sv
// Per-keystroke Enigma sequencer: steps a three-rotor odometer with double-stepping,
// lets the rotor datapath settle, captures the cipher letter and hands it to the display.
module enigma_keystroke_sequencer #(
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned NOTCH_R = 16,
    parameter int unsigned NOTCH_M = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [25:0] key_letter,
    input  logic        load,
    input  logic [14:0] load_pos,
    input  logic [4:0]  cipher_in,
    input  logic        out_ready,
    output logic [25:0] letter_out,
    output logic [4:0]  pos_l,
    output logic [4:0]  pos_m,
    output logic [4:0]  pos_r,
    output logic [4:0]  char_out,
    output logic        char_valid,
    output logic        busy,
    output logic        drop
);

    localparam logic [4:0] NOTCH_R_C  = 5'(NOTCH_R);
    localparam logic [4:0] NOTCH_M_C  = 5'(NOTCH_M);
    localparam logic [3:0] SETTLE_M1  = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STEP   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_EMIT   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  pos_l_q, pos_l_d;
    logic [4:0]  pos_m_q, pos_m_d;
    logic [4:0]  pos_r_q, pos_r_d;
    logic [25:0] letter_q, letter_d;
    logic [4:0]  char_q, char_d;
    logic        char_valid_q, char_valid_d;
    logic        busy_q, busy_d;
    logic        drop_q, drop_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        r_at_notch_s;
    logic        m_at_notch_s;

    function automatic logic [4:0] wrap_inc(input logic [4:0] p);
        return (p == 5'd25) ? 5'd0 : (p + 5'd1);
    endfunction

    function automatic logic [4:0] sanitize(input logic [4:0] p);
        return (p > 5'd25) ? 5'd0 : p;
    endfunction

    function automatic logic is_onehot(input logic [25:0] v);
        return (v != 26'd0) && ((v & (v - 26'd1)) == 26'd0);
    endfunction

    // Notch detection always uses the pre-step positions, which gives the double step.
    always_comb begin
        r_at_notch_s = (pos_r_q == NOTCH_R_C);
        m_at_notch_s = (pos_m_q == NOTCH_M_C);
    end

    // Next-state and next-output computation for the keystroke FSM.
    always_comb begin
        state_d      = state_q;
        pos_l_d      = pos_l_q;
        pos_m_d      = pos_m_q;
        pos_r_d      = pos_r_q;
        letter_d     = letter_q;
        char_d       = char_q;
        char_valid_d = char_valid_q;
        cnt_d        = cnt_q;
        drop_d       = key_valid & (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    pos_l_d = sanitize(load_pos[14:10]);
                    pos_m_d = sanitize(load_pos[9:5]);
                    pos_r_d = sanitize(load_pos[4:0]);
                    drop_d  = key_valid;
                end else if (key_valid) begin
                    if (is_onehot(key_letter)) begin
                        letter_d = key_letter;
                        state_d  = ST_STEP;
                        drop_d   = 1'b0;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else begin
                    drop_d = 1'b0;
                end
            end
            ST_STEP: begin
                pos_r_d = wrap_inc(pos_r_q);
                if (r_at_notch_s || m_at_notch_s) begin
                    pos_m_d = wrap_inc(pos_m_q);
                end else begin
                    pos_m_d = pos_m_q;
                end
                if (m_at_notch_s) begin
                    pos_l_d = wrap_inc(pos_l_q);
                end else begin
                    pos_l_d = pos_l_q;
                end
                cnt_d   = SETTLE_M1;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    char_d       = cipher_in;
                    char_valid_d = 1'b1;
                    state_d      = ST_EMIT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    char_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    char_valid_d = 1'b1;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                char_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset aborts any pending character.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pos_l_q      <= 5'd0;
            pos_m_q      <= 5'd0;
            pos_r_q      <= 5'd0;
            letter_q     <= 26'd0;
            char_q       <= 5'd0;
            char_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            drop_q       <= 1'b0;
            cnt_q        <= 4'd0;
        end else begin
            state_q      <= state_d;
            pos_l_q      <= pos_l_d;
            pos_m_q      <= pos_m_d;
            pos_r_q      <= pos_r_d;
            letter_q     <= letter_d;
            char_q       <= char_d;
            char_valid_q <= char_valid_d;
            busy_q       <= busy_d;
            drop_q       <= drop_d;
            cnt_q        <= cnt_d;
        end
    end

    assign letter_out = letter_q;
    assign pos_l      = pos_l_q;
    assign pos_m      = pos_m_q;
    assign pos_r      = pos_r_q;
    assign char_out   = char_q;
    assign char_valid = char_valid_q;
    assign busy       = busy_q;
    assign drop       = drop_q;

endmodule

// File: tb/tb_enigma_keystroke_sequencer.sv
// Scoreboard bench: stimulus pushes expected characters, a negedge monitor pops and compares.
module tb_enigma_keystroke_sequencer;

    localparam int SETTLE = 2;
    localparam int NR     = 16;
    localparam int NM     = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        key_valid = 1'b0;
    logic [25:0] key_letter = 26'd0;
    logic        load = 1'b0;
    logic [14:0] load_pos = 15'd0;
    logic [4:0]  cipher_in;
    logic        out_ready = 1'b1;
    logic [25:0] letter_out;
    logic [4:0]  pos_l, pos_m, pos_r, char_out;
    logic        char_valid, busy, drop;

    enigma_keystroke_sequencer #(.SETTLE(SETTLE), .NOTCH_R(NR), .NOTCH_M(NM)) dut (
        .clock(clock), .reset(reset), .key_valid(key_valid), .key_letter(key_letter),
        .load(load), .load_pos(load_pos), .cipher_in(cipher_in), .out_ready(out_ready),
        .letter_out(letter_out), .pos_l(pos_l), .pos_m(pos_m), .pos_r(pos_r),
        .char_out(char_out), .char_valid(char_valid), .busy(busy), .drop(drop)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int ch;
        int cyc;
        int l;
        int m;
        int r;
    } exp_t;
    exp_t sbq[$];

    // reference model state
    int ml = 0, mm = 0, mr = 0;
    logic [25:0] last_letter = 26'd0;

    function automatic int letter_idx(input logic [25:0] v);
        for (int i = 0; i < 26; i++) if (v[i]) return i;
        return 0;
    endfunction

    // toy datapath whose output depends on letter, rotors and time
    assign cipher_in = 5'((letter_idx(letter_out) + int'(pos_l) + int'(pos_m) + int'(pos_r) + cyc) % 26);

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_pos(input int l, input int m, input int r);
        check("pos_l", int'(pos_l), l);
        check("pos_m", int'(pos_m), m);
        check("pos_r", int'(pos_r), r);
    endtask

    // monitor: compares every presented character against the scoreboard head
    logic prev_cv = 1'b0;
    always @(negedge clock) begin
        if (char_valid) begin
            if (sbq.size() == 0) begin
                check("sb_unexpected_char", sbq.size(), 1);
            end else begin
                check("char_out", int'(char_out), sbq[0].ch);
                if (!prev_cv) begin
                    check("cv_latency", cyc, sbq[0].cyc);
                    check("mon_pos_l", int'(pos_l), sbq[0].l);
                    check("mon_pos_m", int'(pos_m), sbq[0].m);
                    check("mon_pos_r", int'(pos_r), sbq[0].r);
                end
                if (out_ready) void'(sbq.pop_front());
            end
        end
        prev_cv <= char_valid;
    end

    task automatic wait_idle(input bit rnd);
        int n = 0;
        while (busy && n < 300) begin
            @(posedge clock); #1;
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            n++;
        end
        if (busy) check("idle_timeout", int'(busy), 0);
    endtask

    task automatic model_step();
        bit ms, ls;
        ms = (mr == NR) || (mm == NM);
        ls = (mm == NM);
        mr = (mr + 1) % 26;
        if (ms) mm = (mm + 1) % 26;
        if (ls) ml = (ml + 1) % 26;
    endtask

    // drive one keystroke in IDLE; returns in the following cycle
    task automatic keystroke(input logic [25:0] k, output int c);
        bit ok;
        exp_t e;
        c = cyc;
        key_valid = 1'b1;
        key_letter = k;
        ok = ($countones(k) == 1);
        if (ok) begin
            model_step();
            e.ch = (letter_idx(k) + ml + mm + mr + c + SETTLE + 1) % 26;
            e.cyc = c + SETTLE + 2;
            e.l = ml; e.m = mm; e.r = mr;
            sbq.push_back(e);
        end
        @(posedge clock); #1;
        key_valid = 1'b0;
        check("key_drop", int'(drop), ok ? 0 : 1);
        if (ok) last_letter = k;
        check("letter_out", int'(letter_out), int'(last_letter));
        check("key_busy", int'(busy), ok ? 1 : 0);
    endtask

    task automatic do_load(input int l, input int m, input int r, input bit with_key);
        load = 1'b1;
        load_pos = {5'(l), 5'(m), 5'(r)};
        key_valid = with_key;
        key_letter = 26'd1 << $urandom_range(0, 25);
        ml = (l > 25) ? 0 : l;
        mm = (m > 25) ? 0 : m;
        mr = (r > 25) ? 0 : r;
        @(posedge clock); #1;
        load = 1'b0;
        key_valid = 1'b0;
        check_pos(ml, mm, mr);
        check("load_drop", int'(drop), int'(with_key));
        check("load_busy", int'(busy), 0);
        check("load_letter", int'(letter_out), int'(last_letter));
    endtask

    function automatic logic [25:0] bad_key();
        int a, b;
        logic [25:0] v;
        if ($urandom_range(0, 2) == 0) return 26'd0;
        a = $urandom_range(0, 25);
        b = (a + 1 + $urandom_range(0, 24)) % 26;
        v = (26'd1 << a) | (26'd1 << b);
        return v;
    endfunction

    initial begin
        int c, n;
        logic [25:0] k;

        repeat (3) @(posedge clock);
        #1;
        check("rst_letter", int'(letter_out), 0);
        check_pos(0, 0, 0);
        check("rst_char", int'(char_out), 0);
        check("rst_cv", int'(char_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_drop", int'(drop), 0);
        reset = 1'b0;
        @(posedge clock); #1;

        // plan 1: single A keystroke, latency and one-cycle valid
        out_ready = 1'b1;
        keystroke(26'd1, c);
        repeat (4) @(posedge clock);
        #1;
        check("cv_one_cycle", int'(char_valid), 0);
        check("busy_done", int'(busy), 0);
        check_pos(0, 0, 1);

        // plan 2..4: notch carries, double step, wrap
        do_load(0, 0, 16, 1'b0);
        keystroke(26'd1 << 4, c); wait_idle(1'b0);
        check_pos(0, 1, 17);
        do_load(0, 3, 16, 1'b0);
        keystroke(26'd1 << 7, c); wait_idle(1'b0); check_pos(0, 4, 17);
        keystroke(26'd1 << 8, c); wait_idle(1'b0); check_pos(1, 5, 18);
        keystroke(26'd1 << 9, c); wait_idle(1'b0); check_pos(1, 5, 19);
        do_load(25, 4, 25, 1'b0);
        keystroke(26'd1 << 25, c); wait_idle(1'b0);
        check_pos(0, 5, 0);

        // plan 5: stall, key and load while busy
        out_ready = 1'b0;
        keystroke(26'd1 << $urandom_range(0, 25), c);
        n = 0;
        while (!char_valid && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        check("stall_cv_seen", int'(char_valid), 1);
        repeat (2) @(posedge clock);
        #1;
        key_valid = 1'b1;
        key_letter = 26'd1 << $urandom_range(0, 25);
        @(posedge clock); #1;
        key_valid = 1'b0;
        check("busy_key_drop", int'(drop), 1);
        check("busy_key_letter", int'(letter_out), int'(last_letter));
        load = 1'b1;
        load_pos = 15'($urandom);
        @(posedge clock); #1;
        load = 1'b0;
        check("busy_drop_once", int'(drop), 0);
        check_pos(ml, mm, mr);
        repeat (5) @(posedge clock);
        #1;
        check("stall_cv_held", int'(char_valid), 1);
        out_ready = 1'b1;
        @(posedge clock); #1;
        check("release_cv", int'(char_valid), 0);
        check("release_busy", int'(busy), 0);

        // plan 6: invalid key, then reset during SETTLE
        keystroke(26'h3, c);
        keystroke(26'd0, c);
        keystroke(26'd1 << 12, c);
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        check("mid_rst_letter", int'(letter_out), 0);
        check_pos(0, 0, 0);
        check("mid_rst_char", int'(char_out), 0);
        check("mid_rst_cv", int'(char_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_drop", int'(drop), 0);
        sbq.delete();
        ml = 0; mm = 0; mr = 0; last_letter = 26'd0;
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        // randomized traffic against the model
        for (int it = 0; it < 80; it++) begin
            int op;
            wait_idle(1'b1);
            op = $urandom_range(0, 9);
            if (op == 0)
                do_load($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), 1'b0);
            else if (op == 1)
                do_load($urandom_range(0, 25), $urandom_range(0, 25), $urandom_range(0, 25), 1'b1);
            else if (op == 2)
                keystroke(bad_key(), c);
            else if (op == 3)
                do_load($urandom_range(0, 25), NM, NR, 1'b0);
            else begin
                k = 26'd1 << $urandom_range(0, 25);
                keystroke(k, c);
            end
        end
        wait_idle(1'b0);
        @(posedge clock); #1;
        check("sb_drained", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
